ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch stage of the MIPS core. It sits directly upstream of decode (opcode/funct split, control unit, register-file read) and owns the program counter. It issues word reads to a synchronous-read instruction memory. It delivers `{pc, pc+4, instr}` to decode over a valid/ready handshake through a 2-entry buffer. Branch/jump redirects from later stages load the PC and flush all fetched-but-unconsumed instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word aligned.
- `IMEM_AW`, 7: instruction memory word-address width (128 words = 512 bytes).

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_en` out 1: read request this cycle.
- `imem_addr` out IMEM_AW: word address, `pc[IMEM_AW+1:2]`.
- `imem_rdata` in 32: read data, valid exactly one cycle after `imem_en`.
- `redirect_valid` in 1: taken branch / j / jal / jr from a later stage.
- `redirect_pc` in 32: target byte address; bits [1:0] ignored (forced 0).
- `out_valid` out 1: decode bundle available.
- `out_ready` in 1: decode accepts the bundle.
- `out_pc` out 32: byte address of `out_instr`.
- `out_pc_4` out 32: `out_pc + 4`, used by jal link and branch offset.
- `out_instr` out 32: instruction word.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: a read was issued last cycle.
  - A 2-entry FIFO of `{pc, instr}` with `count` 0..2.
- A transfer occurs when `out_valid & out_ready`; it pops the FIFO head.
- Issue rule: `imem_en = !rst & !redirect_valid & (count + inflight - pop < 2)`.
  - On issue, `pc <= pc + 4`, wrapping modulo 2^32.
  - The issued pc is held in a 1-deep tag register alongside `inflight`.
- Response: if `inflight`, push `{tag_pc, imem_rdata}` into the FIFO. The credit rule guarantees the FIFO never overflows.
- Redirect, when `redirect_valid` is high:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO cleared and `inflight` cleared; the response arriving next cycle is discarded.
  - No issue in that cycle.
  - A transfer in the same cycle still completes (decode consumed it); all other entries are dropped.
- Memory aliasing: addresses above 4·2^IMEM_AW alias through `imem_addr` truncation. No fault is raised.
- `out_*` reflect the FIFO head. `out_pc_4` is computed combinationally from the head pc.

## Timing
- Reset values:
  - `pc = RESET_PC`, `count = 0`, `inflight = 0`.
  - `out_valid = 0`, `out_pc = 0`, `out_pc_4 = 4`, `out_instr = 0`, `imem_en = 0`.
- Latency: issue in cycle N, FIFO write at the end of N+1, `out_valid` in N+2. The first `out_valid` occurs 2 cycles after `rst` falls.
- Throughput: 1 instruction/cycle sustained while `out_ready = 1`, with steady state `count = 1`, `inflight = 1`.
- Redirect penalty: redirect in cycle R, issue at the target in R+1, target instruction valid in R+3.
- Backpressure: with `out_ready = 0`, at most 2 instructions are held. `imem_en` stays 0 until a pop frees credit.
- Handshake: while `out_valid = 1` and no transfer, `out_pc` and `out_instr` are stable, except when redirect or reset clears them.
- Reset mid-operation: it takes priority over redirect and the handshake. Any accepted transfer in the reset cycle is lost by definition.

## Structure
- Shared package `mips_pkg`:
  - `INSTR_W = 32`.
  - `RESET_VECTOR` constant.
  - `NOP = 32'h0000_0000`.
  - Typedef `fetch_bundle_t {pc, instr}`.
- Sub-module `fetch_fifo2`: 2-entry synchronous FIFO of `fetch_bundle_t` with push/pop/flush, `count` output, and sync active-high reset.
- PC, credit and tag logic live in `ifetch`.

## Test plan
- Release `rst`, `out_ready = 1`, mem[i] = i: `out_valid` 2 cycles after release; (out_pc, out_instr) = (0,0), (4,1), (8,2), … one per cycle; `out_pc_4 = out_pc + 4`.
- First valid, then `out_ready = 0` for 3 cycles: `out_pc` holds 0, `imem_en` is 0 after 2 credits are used; on release the sequence is 0, 4, 8 with no gap or duplicate.
- FIFO full (pc 0, 4), `redirect_valid` with `redirect_pc = 0x43`: 0x4 and 0x8 never appear; the next bundle is pc 0x40 three cycles later.
- Redirect to 0x80 in the same cycle as a handshake of pc 0x10: 0x10 counts as accepted; the next delivered pc is 0x80.
- `rst` held 1 cycle while `out_valid = 1`: `out_valid = 0` next cycle; fetch restarts at RESET_PC with 2-cycle latency.
- `RESET_PC = 0x1FC`, `IMEM_AW = 7`: `imem_addr` 127 then 0; `out_pc` 0x1FC then 0x200; instr = mem[0] on the second.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Types and constants shared by the MIPS core pipeline stages.
//   INSTR_W        : instruction word width
//   RESET_VECTOR   : default byte address fetched after reset
//   NOP            : all-zero instruction (sll $0,$0,0)
//   fetch_bundle_t : {pc, instr} pair carried from fetch towards decode
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_bundle_t;

endpackage

// File: rtl/ifetch_if.sv
// -----------------------------------------------------------------------------
// ifetch_if
// Fetch-to-decode handshake. A bundle moves when out_valid & out_ready.
//   out_valid : fetch holds a bundle for decode
//   out_ready : decode accepts the bundle this cycle
//   out_pc    : byte address of out_instr
//   out_pc_4  : out_pc + 4 (jal link value, branch offset base)
//   out_instr : instruction word
// master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface ifetch_if;
  import mips_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_pc;
  logic [31:0]        out_pc_4;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_pc_4,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_pc_4,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry synchronous FIFO of fetch bundles.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data at the tail
//   push_data : bundle to write
//   pop       : drop the head entry (only when count != 0)
//   flush     : discard all entries; overrides push and pop
//   head      : current head entry (meaningful only when count != 0)
//   count     : number of valid entries, 0..2
// The owner guarantees no push into a full FIFO without a matching pop.
// -----------------------------------------------------------------------------
module fetch_fifo2
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_bundle_t push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_bundle_t head,
  output logic [1:0]    count
);

  fetch_bundle_t mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents
  // are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and hands {pc, pc+4, instr} to decode.
//   clk            : clock
//   rst            : synchronous active-high reset
//   imem_en        : issue a read this cycle
//   imem_addr      : word address, pc[IMEM_AW+1:2]
//   imem_rdata     : read data, valid one cycle after imem_en
//   redirect_valid : taken branch/jump from a later stage
//   redirect_pc    : redirect target byte address (bits [1:0] ignored)
//   dec            : handshake towards decode (ifetch_if.master)
// Credit rule: a read is issued only when the FIFO plus the read in flight,
// less this cycle's pop, leaves room, so responses always fit.
// -----------------------------------------------------------------------------
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          IMEM_AW  = 7
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  ifetch_if.master           dec
);

  logic [31:0]   pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic [1:0]    count;
  logic [2:0]    occupancy;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic [31:0]   target_pc;
  logic [31:0]   out_pc;
  fetch_bundle_t head;
  fetch_bundle_t push_data;

  assign head_valid = (count != 2'd0);
  assign pop        = head_valid & dec.out_ready;

  // Entries that will still be owed space after this cycle's pop.
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_en    = !rst && !redirect_valid && (occupancy < 3'd2);
  assign imem_addr  = pc[IMEM_AW+1:2];

  // A response landing in a redirect cycle belongs to the old path.
  assign push       = inflight & !redirect_valid;
  assign target_pc  = redirect_pc & ~32'h3;
  assign push_data  = '{pc: tag_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC & ~32'h3;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (redirect_valid) pc <= target_pc;
      else if (imem_en)   pc <= pc + 32'd4;
    end
  end

  // Only meaningful while inflight is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (imem_en) tag_pc <= pc;
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  // Empty FIFO presents a zero bundle so decode never sees stale data.
  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    out_pc        = '0;
    dec.out_instr = NOP;
    if (head_valid) begin
      out_pc        = head.pc;
      dec.out_instr = head.instr;
    end
  end

  assign dec.out_valid = head_valid;
  assign dec.out_pc    = out_pc;
  assign dec.out_pc_4  = out_pc + 32'd4;

endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Directed bench for ifetch. u_dut uses the default reset vector; u_alias
// starts at 0x1FC to exercise address wrap through imem_addr truncation.
// Both fetch from a 128-word memory model holding mem[i] = i.
// -----------------------------------------------------------------------------
module tb_ifetch;
  import mips_pkg::*;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_en;
    logic [6:0]  exp_addr;
  } vec_t;

  localparam int N_VEC = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        rv;
  logic [31:0] rpc;

  logic        en1;
  logic        en2;
  logic [6:0]  addr1;
  logic [6:0]  addr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [N_VEC];

  always #5 clk = ~clk;

  ifetch_if dec1 ();
  ifetch_if dec2 ();

  assign dec1.out_ready = ready;
  assign dec2.out_ready = ready;

  ifetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (en1),
    .imem_addr      (addr1),
    .imem_rdata     (rdata1),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .dec            (dec1)
  );

  ifetch #(.RESET_PC(32'h0000_01FC), .IMEM_AW(7)) u_alias (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (en2),
    .imem_addr      (addr2),
    .imem_rdata     (rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .dec            (dec2)
  );

  // Synchronous-read instruction memories.
  always @(posedge clk) begin
    if (en1) rdata1 <= mem[addr1];
    if (en2) rdata2 <= mem[addr2];
  end

  function automatic vec_t mk(logic r, logic rdy, logic v, logic [31:0] p,
                              logic [31:0] i, logic e, logic [6:0] a);
    vec_t t;
    t.rst       = r;
    t.ready     = rdy;
    t.exp_valid = v;
    t.exp_pc    = p;
    t.exp_instr = i;
    t.exp_en    = e;
    t.exp_addr  = a;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, return mid-cycle for sampling.
  task automatic step(input logic r, input logic rdy, input logic v, input logic [31:0] p);
    @(posedge clk);
    #1;
    rst   = r;
    ready = rdy;
    rv    = v;
    rpc   = p;
    #4;
  endtask

  // which = 0 : u_dut, which = 1 : u_alias. pc_4 is expected as pc + 4.
  task automatic expect_out(input int which, input string tag, input logic v,
                            input logic [31:0] p, input logic [31:0] i,
                            input logic e, input logic [6:0] a);
    logic        a_valid;
    logic [31:0] a_pc;
    logic [31:0] a_pc_4;
    logic [31:0] a_instr;
    logic        a_en;
    logic [6:0]  a_addr;
    if (which == 0) begin
      a_valid = dec1.out_valid; a_pc = dec1.out_pc; a_pc_4 = dec1.out_pc_4;
      a_instr = dec1.out_instr; a_en = en1;         a_addr = addr1;
    end else begin
      a_valid = dec2.out_valid; a_pc = dec2.out_pc; a_pc_4 = dec2.out_pc_4;
      a_instr = dec2.out_instr; a_en = en2;         a_addr = addr2;
    end
    check({tag, " out_valid"}, 32'(a_valid), 32'(v));
    check({tag, " out_pc"},    a_pc,    p);
    check({tag, " out_pc_4"},  a_pc_4,  p + 32'd4);
    check({tag, " out_instr"}, a_instr, i);
    check({tag, " imem_en"},   32'(a_en), 32'(e));
    if (e) check({tag, " imem_addr"}, 32'(a_addr), 32'(a));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i);

    // Startup stream, reset while valid, then 3 cycles of backpressure.
    //             rst rdy val pc         instr      en addr
    vecs[0]  = mk(1, 1, 0, 32'h00, 32'd0, 0, 7'd0);
    vecs[1]  = mk(0, 1, 0, 32'h00, 32'd0, 1, 7'd0);
    vecs[2]  = mk(0, 1, 0, 32'h00, 32'd0, 1, 7'd1);
    vecs[3]  = mk(0, 1, 1, 32'h00, 32'd0, 1, 7'd2);
    vecs[4]  = mk(0, 1, 1, 32'h04, 32'd1, 1, 7'd3);
    vecs[5]  = mk(0, 1, 1, 32'h08, 32'd2, 1, 7'd4);
    vecs[6]  = mk(0, 1, 1, 32'h0C, 32'd3, 1, 7'd5);
    vecs[7]  = mk(1, 1, 1, 32'h10, 32'd4, 0, 7'd0);
    vecs[8]  = mk(0, 1, 0, 32'h00, 32'd0, 1, 7'd0);
    vecs[9]  = mk(0, 1, 0, 32'h00, 32'd0, 1, 7'd1);
    vecs[10] = mk(0, 0, 1, 32'h00, 32'd0, 0, 7'd0);
    vecs[11] = mk(0, 0, 1, 32'h00, 32'd0, 0, 7'd0);
    vecs[12] = mk(0, 0, 1, 32'h00, 32'd0, 0, 7'd0);
    vecs[13] = mk(0, 1, 1, 32'h00, 32'd0, 1, 7'd2);
    vecs[14] = mk(0, 1, 1, 32'h04, 32'd1, 1, 7'd3);
    vecs[15] = mk(0, 1, 1, 32'h08, 32'd2, 1, 7'd4);
    vecs[16] = mk(0, 1, 1, 32'h0C, 32'd3, 1, 7'd5);

    rst = 1'b1; ready = 1'b1; rv = 1'b0; rpc = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < N_VEC; i++) begin
      step(vecs[i].rst, vecs[i].ready, 1'b0, 32'h0);
      expect_out(0, $sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                 vecs[i].exp_instr, vecs[i].exp_en, vecs[i].exp_addr);
    end

    // Redirect to 0x43 while the FIFO holds pc 0 and 4.
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);  expect_out(0, "full c0", 0, 32'h0, 32'd0, 1, 7'd0);
    step(0, 1, 0, 32'h0);  expect_out(0, "full c1", 0, 32'h0, 32'd0, 1, 7'd1);
    step(0, 0, 0, 32'h0);  expect_out(0, "full c2", 1, 32'h0, 32'd0, 0, 7'd0);
    step(0, 0, 1, 32'h43); expect_out(0, "full R",  1, 32'h0, 32'd0, 0, 7'd0);
    step(0, 1, 0, 32'h0);  expect_out(0, "full R+1", 0, 32'h0, 32'd0, 1, 7'd16);
    step(0, 1, 0, 32'h0);  expect_out(0, "full R+2", 0, 32'h0, 32'd0, 1, 7'd17);
    step(0, 1, 0, 32'h0);  expect_out(0, "full R+3", 1, 32'h40, 32'd16, 1, 7'd18);
    step(0, 1, 0, 32'h0);  expect_out(0, "full R+4", 1, 32'h44, 32'd17, 1, 7'd19);

    // Redirect to 0x80 in the same cycle decode accepts pc 0x10.
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);  expect_out(0, "hs c0", 0, 32'h0, 32'd0, 1, 7'd0);
    step(0, 1, 0, 32'h0);  expect_out(0, "hs c1", 0, 32'h0, 32'd0, 1, 7'd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 32'h0);
      expect_out(0, $sformatf("hs stream%0d", k), 1, 32'(4 * k), 32'(k), 1, 7'(k + 2));
    end
    step(0, 1, 1, 32'h80); expect_out(0, "hs R",   1, 32'h10, 32'd4, 0, 7'd0);
    step(0, 1, 0, 32'h0);  expect_out(0, "hs R+1", 0, 32'h0, 32'd0, 1, 7'd32);
    step(0, 1, 0, 32'h0);  expect_out(0, "hs R+2", 0, 32'h0, 32'd0, 1, 7'd33);
    step(0, 1, 0, 32'h0);  expect_out(0, "hs R+3", 1, 32'h80, 32'd32, 1, 7'd34);

    // Wrap past the top of the 128-word memory from reset vector 0x1FC.
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);  expect_out(1, "alias c0", 0, 32'h0, 32'd0, 1, 7'd127);
    step(0, 1, 0, 32'h0);  expect_out(1, "alias c1", 0, 32'h0, 32'd0, 1, 7'd0);
    step(0, 1, 0, 32'h0);  expect_out(1, "alias c2", 1, 32'h1FC, 32'd127, 1, 7'd1);
    step(0, 1, 0, 32'h0);  expect_out(1, "alias c3", 1, 32'h200, 32'd0, 1, 7'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
